// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note-on/note-off events one at a time,
// scans every voice over NUM_VOICES cycles to find a matching, a free and the
// oldest voice, then commits the event to one voice in a single edge.
//
// Event handshake: an event is accepted on a rising edge where ev_valid and
// ev_ready are both 1. ev_ready is high only while idle, so ev_valid held
// during a scan is ignored, and ev_* only matter on the accepting edge.
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int FREQ_RES_BITS = 8,
    parameter int VOLUME_BITS   = 8,
    parameter int NOTE_BITS     = 7,
    parameter int AGE_BITS      = 8
) (
    input  logic                                mclk,
    input  logic                                rst_n,
    input  logic                                ev_valid,
    output logic                                ev_ready,
    input  logic                                ev_on,
    input  logic [NOTE_BITS-1:0]                ev_note,
    input  logic [FREQ_RES_BITS-1:0]            ev_freq,
    input  logic [VOLUME_BITS-1:0]              ev_vel,
    output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
    output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_vol,
    output logic [NUM_VOICES-1:0]               voice_active,
    output logic [NUM_VOICES-1:0]               voice_rst,
    output logic                                steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t state_q, state_d;
    logic   armed_q;
    logic   accept;

    // Per-voice state.
    logic [FREQ_RES_BITS-1:0] freq_q   [NUM_VOICES];
    logic [VOLUME_BITS-1:0]   vol_q    [NUM_VOICES];
    logic [NOTE_BITS-1:0]     note_q   [NUM_VOICES];
    logic [AGE_BITS-1:0]      age_q    [NUM_VOICES];
    logic [NUM_VOICES-1:0]    active_q;
    logic [NUM_VOICES-1:0]    rst_pulse_q;
    logic                     steal_q;

    // Latched event (ev_on with zero velocity is folded into note-off here).
    logic                     lat_on;
    logic [NOTE_BITS-1:0]     lat_note;
    logic [FREQ_RES_BITS-1:0] lat_freq;
    logic [VOLUME_BITS-1:0]   lat_vel;

    // Scan cursor and candidates.
    logic [IDX_W-1:0]    idx_q;
    logic                match_found, free_found, old_found;
    logic [IDX_W-1:0]    match_idx, free_idx, old_idx;
    logic [AGE_BITS-1:0] old_age;

    logic [IDX_W-1:0]    target;
    logic                is_steal;

    assign ev_ready = armed_q && (state_q == IDLE);
    assign accept   = ev_valid && ev_ready;

    // State register; armed_q keeps ev_ready low until the first edge after reset.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state logic: one scan cycle per voice, then a single commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Target selection for a note-on: retrigger a match, else a free voice, else steal the oldest.
    always_comb begin
        target   = old_idx;
        is_steal = 1'b0;
        if (match_found)     target = match_idx;
        else if (free_found) target = free_idx;
        else                 is_steal = 1'b1;
    end

    // Datapath: latch the event, accumulate scan candidates, apply the commit.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
            active_q    <= '0;
            rst_pulse_q <= '0;
            steal_q     <= 1'b0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_freq    <= '0;
            lat_vel     <= '0;
            idx_q       <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            rst_pulse_q <= '0;
            steal_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lat_on      <= ev_on && (ev_vel != '0);
                        lat_note    <= ev_note;
                        lat_freq    <= ev_freq;
                        lat_vel     <= ev_vel;
                        idx_q       <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (active_q[idx_q] && (note_q[idx_q] == lat_note) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx_q;
                    end
                    if (!active_q[idx_q] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx_q;
                    end
                    // Strict greater-than keeps the lowest index on an age tie.
                    if (active_q[idx_q] && (!old_found || (age_q[idx_q] > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= idx_q;
                        old_age   <= age_q[idx_q];
                    end
                    idx_q <= idx_q + 1'b1;
                end
                COMMIT: begin
                    if (lat_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == target) begin
                                freq_q[i]      <= lat_freq;
                                vol_q[i]       <= lat_vel;
                                note_q[i]      <= lat_note;
                                age_q[i]       <= '0;
                                active_q[i]    <= 1'b1;
                                rst_pulse_q[i] <= 1'b1;
                            end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                                age_q[i] <= age_q[i] + 1'b1;
                            end
                        end
                        steal_q <= is_steal;
                    end else if (match_found) begin
                        active_q[match_idx] <= 1'b0;
                        vol_q[match_idx]    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack per-voice registers onto the flat output buses.
    always_comb begin
        voice_freq = '0;
        voice_vol  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_freq[i*FREQ_RES_BITS +: FREQ_RES_BITS] = freq_q[i];
            voice_vol[i*VOLUME_BITS +: VOLUME_BITS]      = vol_q[i];
        end
    end

    assign voice_active = active_q;
    assign voice_rst    = rst_pulse_q;
    assign steal        = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices, 8-bit freq/volume).
module tb_voice_allocator;

    logic        mclk;
    logic        rst_n;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [7:0]  ev_freq;
    logic [7:0]  ev_vel;
    logic [31:0] voice_freq;
    logic [31:0] voice_vol;
    logic [3:0]  voice_active;
    logic [3:0]  voice_rst;
    logic        steal;

    int total;
    int bad;

    voice_allocator dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_freq      (ev_freq),
        .ev_vel       (ev_vel),
        .voice_freq   (voice_freq),
        .voice_vol    (voice_vol),
        .voice_active (voice_active),
        .voice_rst    (voice_rst),
        .steal        (steal)
    );

    // Clock
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic        on;
        logic [6:0]  note;
        logic [7:0]  freq;
        logic [7:0]  vel;
        logic [31:0] e_freq;
        logic [31:0] e_vol;
        logic [3:0]  e_act;
        logic [3:0]  e_rst;
        logic        e_steal;
    } vec_t;

    vec_t vecs[13];

    logic [31:0] prev_freq, prev_vol;
    logic [3:0]  prev_act;

    function automatic vec_t mk(input logic on, input logic [6:0] note, input logic [7:0] freq,
                                input logic [7:0] vel, input logic [31:0] e_freq,
                                input logic [31:0] e_vol, input logic [3:0] e_act,
                                input logic [3:0] e_rst, input logic e_steal);
        vec_t v;
        v.on = on; v.note = note; v.freq = freq; v.vel = vel;
        v.e_freq = e_freq; v.e_vol = e_vol; v.e_act = e_act; v.e_rst = e_rst; v.e_steal = e_steal;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver + checker for one event: bounded wait for ready, accept, count busy
    // cycles, check the committed outputs and that pulses drop after one cycle.
    task automatic apply(input vec_t v, input int n);
        int  w;
        int  busy;
        bit  quiet;
        string tag;
        tag = $sformatf("v%0d", n);
        w = 0;
        while (!ev_ready && w < 20) begin
            @(negedge mclk);
            w++;
        end
        check({tag, "_ready_wait"}, 64'(ev_ready), 64'd1);
        ev_valid = 1'b1;
        ev_on    = v.on;
        ev_note  = v.note;
        ev_freq  = v.freq;
        ev_vel   = v.vel;
        busy  = 0;
        quiet = 1'b1;
        @(negedge mclk);
        // Keep ev_valid high and scramble ev_* while busy: none of it may be taken.
        while (!ev_ready && busy < 20) begin
            busy++;
            if (voice_rst !== 4'd0 || steal !== 1'b0 || voice_freq !== prev_freq ||
                voice_vol !== prev_vol || voice_active !== prev_act) quiet = 1'b0;
            ev_on   = 1'($urandom_range(0, 1));
            ev_note = 7'($urandom_range(0, 127));
            ev_freq = 8'($urandom_range(0, 255));
            ev_vel  = 8'($urandom_range(0, 255));
            @(negedge mclk);
        end
        ev_valid = 1'b0;
        check({tag, "_busy_cycles"}, 64'(busy), 64'd5);
        check({tag, "_quiet_while_busy"}, 64'(quiet), 64'd1);
        check({tag, "_freq"}, 64'(voice_freq), 64'(v.e_freq));
        check({tag, "_vol"}, 64'(voice_vol), 64'(v.e_vol));
        check({tag, "_active"}, 64'(voice_active), 64'(v.e_act));
        check({tag, "_rst_pulse"}, 64'(voice_rst), 64'(v.e_rst));
        check({tag, "_steal"}, 64'(steal), 64'(v.e_steal));
        @(negedge mclk);
        check({tag, "_pulses_clear"}, 64'({voice_rst, steal}), 64'd0);
        prev_freq = v.e_freq;
        prev_vol  = v.e_vol;
        prev_act  = v.e_act;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_freq  = '0;
        ev_vel   = '0;
        prev_freq = '0;
        prev_vol  = '0;
        prev_act  = '0;

        //                on    note   freq   vel    e_freq        e_vol         e_act    e_rst    steal
        vecs[0]  = mk(1'b1, 7'd60, 8'd10, 8'd100, 32'h0000000a, 32'h00000064, 4'b0001, 4'b0001, 1'b0);
        vecs[1]  = mk(1'b1, 7'd61, 8'd11, 8'd100, 32'h00000b0a, 32'h00006464, 4'b0011, 4'b0010, 1'b0);
        vecs[2]  = mk(1'b1, 7'd62, 8'd12, 8'd100, 32'h000c0b0a, 32'h00646464, 4'b0111, 4'b0100, 1'b0);
        vecs[3]  = mk(1'b1, 7'd63, 8'd13, 8'd100, 32'h0d0c0b0a, 32'h64646464, 4'b1111, 4'b1000, 1'b0);
        vecs[4]  = mk(1'b1, 7'd64, 8'd14, 8'd100, 32'h0d0c0b0e, 32'h64646464, 4'b1111, 4'b0001, 1'b1);
        vecs[5]  = mk(1'b0, 7'd62, 8'h55, 8'h77, 32'h0d0c0b0e, 32'h64006464, 4'b1011, 4'b0000, 1'b0);
        vecs[6]  = mk(1'b0, 7'd99, 8'h56, 8'h78, 32'h0d0c0b0e, 32'h64006464, 4'b1011, 4'b0000, 1'b0);
        vecs[7]  = mk(1'b1, 7'd70, 8'h14, 8'h50, 32'h0d140b0e, 32'h64506464, 4'b1111, 4'b0100, 1'b0);
        vecs[8]  = mk(1'b1, 7'd61, 8'd11, 8'd50,  32'h0d140b0e, 32'h64503264, 4'b1111, 4'b0010, 1'b0);
        vecs[9]  = mk(1'b1, 7'd63, 8'h99, 8'd0,   32'h0d140b0e, 32'h00503264, 4'b0111, 4'b0000, 1'b0);
        vecs[10] = mk(1'b1, 7'd80, 8'h21, 8'h40, 32'h21140b0e, 32'h40503264, 4'b1111, 4'b1000, 1'b0);
        // Ages now v0=3,v1=1,v2=2,v3=0 -> steal v0; then v2 becomes oldest.
        vecs[11] = mk(1'b1, 7'd81, 8'h22, 8'h41, 32'h21140b22, 32'h40503241, 4'b1111, 4'b0001, 1'b1);
        vecs[12] = mk(1'b1, 7'd82, 8'h23, 8'h42, 32'h21230b22, 32'h40423241, 4'b1111, 4'b0100, 1'b1);

        // Reset state and release.
        repeat (3) @(negedge mclk);
        check("rst_outputs", {voice_freq, voice_vol}, 64'd0);
        check("rst_flags", 64'({voice_active, voice_rst, steal, ev_ready}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(ev_ready), 64'd0);
        @(negedge mclk);
        check("ready_after_edge", 64'(ev_ready), 64'd1);
        check("no_pulse_after_rst", 64'({voice_rst, steal}), 64'd0);

        for (int i = 0; i < 13; i++) apply(vecs[i], i);

        // Reset in the middle of a scan: everything silent at once, event dropped.
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd90;
        ev_freq  = 8'h77;
        ev_vel   = 8'h33;
        @(negedge mclk);
        ev_valid = 1'b0;
        @(negedge mclk);
        rst_n = 1'b0;
        #1;
        check("midscan_rst_bus", {voice_freq, voice_vol}, 64'd0);
        check("midscan_rst_flags", 64'({voice_active, voice_rst, steal, ev_ready}), 64'd0);
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        check("post_rst_ready", 64'(ev_ready), 64'd1);
        repeat (6) @(negedge mclk);
        check("post_rst_dropped", {voice_freq, voice_vol}, 64'd0);
        check("post_rst_flags", 64'({voice_active, voice_rst, steal}), 64'd0);
        prev_freq = '0;
        prev_vol  = '0;
        prev_act  = '0;
        apply(mk(1'b1, 7'd5, 8'h31, 8'h21, 32'h00000031, 32'h00000021, 4'b0001, 4'b0001, 1'b0), 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
